// File: rtl/pool_frame_buffer_pkg.sv
// Shared CNN constants and types: pixel vector, layer-1 pooled frame geometry,
// and the frame-buffer writer/reader state encodings.
package cnn_pkg;
   localparam int PIX_WIDTH    = 16;
   localparam int PIX_CHANNELS = 6;
   localparam int L1_ROWS      = 14;
   localparam int L1_COLS      = 14;
   localparam int FRAME        = L1_ROWS * L1_COLS;

   typedef logic signed [PIX_WIDTH-1:0] pixel_t [PIX_CHANNELS];

   typedef enum logic {WR_ACCEPT, WR_DROP}  wr_state_t;
   typedef enum logic {RD_IDLE,   RD_STREAM} rd_state_t;
endpackage

// File: rtl/pool_frame_buffer_if.sv
// Pooled-pixel capture strobe plus the valid/ready replay stream and status.
interface pool_frame_buffer_if #(
   parameter int DATA_WIDTH   = cnn_pkg::PIX_WIDTH,
   parameter int NUM_CHANNELS = cnn_pkg::PIX_CHANNELS,
   parameter int NUM_ROWS     = cnn_pkg::L1_ROWS,
   parameter int NUM_COLS     = cnn_pkg::L1_COLS
);
   localparam int RW = $clog2(NUM_ROWS);
   localparam int CW = $clog2(NUM_COLS);

   logic signed [DATA_WIDTH-1:0] i_features [NUM_CHANNELS];
   logic                         i_nd;
   logic signed [DATA_WIDTH-1:0] o_features [NUM_CHANNELS];
   logic                         o_valid;
   logic                         i_ready;
   logic [RW-1:0]                o_row;
   logic [CW-1:0]                o_col;
   logic                         o_first;
   logic                         o_last;
   logic                         o_overflow;
   logic [7:0]                   o_drop_cnt;

   modport slave (
      input  i_features, i_nd, i_ready,
      output o_features, o_valid, o_row, o_col, o_first, o_last, o_overflow, o_drop_cnt
   );
   modport master (
      output i_features, i_nd, i_ready,
      input  o_features, o_valid, o_row, o_col, o_first, o_last, o_overflow, o_drop_cnt
   );
endinterface

// File: rtl/pool_frame_buffer_skid_buf.sv
// Two-entry valid/ready buffer carrying a pixel vector with its row/col/first/last tags.
module pixel_skid_buf #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_CHANNELS = 6,
   parameter int ROW_W        = 4,
   parameter int COL_W        = 4
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_data [NUM_CHANNELS],
   input  logic [ROW_W-1:0]             in_row,
   input  logic [COL_W-1:0]             in_col,
   input  logic                         in_first,
   input  logic                         in_last,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] out_data [NUM_CHANNELS],
   output logic [ROW_W-1:0]             out_row,
   output logic [COL_W-1:0]             out_col,
   output logic                         out_first,
   output logic                         out_last,
   output logic [1:0]                   count
);
   localparam int PW = DATA_WIDTH * NUM_CHANNELS;
   localparam int EW = PW + 2 + COL_W + ROW_W;

   logic [EW-1:0] in_ent, head, tail;
   logic [PW-1:0] in_vec;
   logic          pop;

   always_comb begin
      in_vec = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++)
         in_vec[c*DATA_WIDTH +: DATA_WIDTH] = in_data[c];
      in_ent = {in_row, in_col, in_first, in_last, in_vec};
   end

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready;

   // Head register feeds the outputs directly, so it only moves on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         case ({in_valid, pop})
            2'b10: begin
               if (count == 2'd0) head <= in_ent;
               else               tail <= in_ent;
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) head <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  head <= tail;
                  tail <= in_ent;
               end else begin
                  head <= in_ent;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++)
         out_data[c] = head[c*DATA_WIDTH +: DATA_WIDTH];
      out_last  = head[PW];
      out_first = head[PW+1];
      out_col   = head[PW+2 +: COL_W];
      out_row   = head[PW+2+COL_W +: ROW_W];
   end
endmodule

// File: rtl/pool_frame_buffer.sv
// Double-buffered pooled-feature frame store: captures raster pixels into two
// banks and replays each completed frame over valid/ready with row/col tags.
module pool_frame_buffer
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH   = PIX_WIDTH,
   parameter int NUM_CHANNELS = PIX_CHANNELS,
   parameter int NUM_ROWS     = L1_ROWS,
   parameter int NUM_COLS     = L1_COLS
)(
   input logic                i_clk,
   input logic                i_rst_n,
   pool_frame_buffer_if.slave bus
);
   localparam int FRAME_N = NUM_ROWS * NUM_COLS;
   localparam int AW      = $clog2(FRAME_N);
   localparam int RW      = $clog2(NUM_ROWS);
   localparam int CW      = $clog2(NUM_COLS);
   localparam int PW      = DATA_WIDTH * NUM_CHANNELS;

   wr_state_t     wr_state, wr_state_nx;
   logic          wr_bank;
   logic [AW-1:0] wr_addr;
   logic          wr_last, accept_new, accept, wr_en;
   logic [PW-1:0] wr_word;
   logic [1:0]    full;
   logic          overflow;
   logic [7:0]    drop_cnt;

   rd_state_t     rd_state, rd_state_nx;
   logic          rd_bank, rd_all, issue, pop, release_bank;
   logic [AW-1:0] rd_addr;
   logic [RW-1:0] iss_row, pend_row;
   logic [CW-1:0] iss_col, pend_col;
   logic          pend, pend_first, pend_last;
   logic [1:0]    skid_cnt;
   logic [2:0]    occ;
   logic [PW-1:0] mem0 [FRAME_N];
   logic [PW-1:0] mem1 [FRAME_N];
   logic [PW-1:0] rd_q;
   logic signed [DATA_WIDTH-1:0] rd_pix [NUM_CHANNELS];

   always_comb begin
      wr_word = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         wr_word[c*DATA_WIDTH +: DATA_WIDTH] = bus.i_features[c];
         rd_pix[c] = rd_q[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign pop          = bus.o_valid && bus.i_ready;
   assign release_bank = (rd_state == RD_STREAM) && pop && bus.o_last;
   assign wr_last      = (wr_addr == AW'(FRAME_N - 1));
   // A bank freed by the reader on this very edge counts as free for the writer.
   assign accept_new   = !full[wr_bank] || (release_bank && (rd_bank == wr_bank));
   assign accept       = (wr_addr == '0) ? accept_new : (wr_state == WR_ACCEPT);
   assign wr_en        = bus.i_nd && accept;

   always_comb begin
      wr_state_nx = wr_state;
      if (bus.i_nd && (wr_addr == '0))
         wr_state_nx = accept_new ? WR_ACCEPT : WR_DROP;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_state <= WR_ACCEPT;
         wr_bank  <= 1'b0;
         wr_addr  <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         wr_state <= wr_state_nx;
         if (bus.i_nd) begin
            wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
            if (wr_last && accept) wr_bank <= ~wr_bank;
            if (wr_last && !accept) begin
               overflow <= 1'b1;
               if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         full <= '0;
      end else begin
         if (release_bank) full[rd_bank] <= 1'b0;
         if (bus.i_nd && wr_last && accept) full[wr_bank] <= 1'b1;
      end
   end

   assign bus.o_overflow = overflow;
   assign bus.o_drop_cnt = drop_cnt;

   // Issue reads already in RD_IDLE once full is seen, so o_valid follows full by one more edge.
   always_comb begin
      rd_state_nx = rd_state;
      occ         = 3'(skid_cnt) + 3'(pend) - 3'(pop);
      issue       = ((rd_state == RD_STREAM) || full[rd_bank]) && !rd_all && (occ <= 3'd1);
      case (rd_state)
         RD_IDLE:   if (full[rd_bank]) rd_state_nx = RD_STREAM;
         RD_STREAM: if (release_bank)  rd_state_nx = RD_IDLE;
         default:   rd_state_nx = RD_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_state   <= RD_IDLE;
         rd_bank    <= 1'b0;
         rd_addr    <= '0;
         rd_all     <= 1'b0;
         iss_row    <= '0;
         iss_col    <= '0;
         pend       <= 1'b0;
         pend_row   <= '0;
         pend_col   <= '0;
         pend_first <= 1'b0;
         pend_last  <= 1'b0;
      end else begin
         rd_state <= rd_state_nx;
         pend     <= issue;
         if (issue) begin
            pend_row   <= iss_row;
            pend_col   <= iss_col;
            pend_first <= (iss_row == '0) && (iss_col == '0);
            pend_last  <= (iss_row == RW'(NUM_ROWS - 1)) && (iss_col == CW'(NUM_COLS - 1));
            if (rd_addr == AW'(FRAME_N - 1)) begin
               rd_all  <= 1'b1;
               rd_addr <= '0;
               iss_row <= '0;
               iss_col <= '0;
            end else begin
               rd_addr <= rd_addr + 1'b1;
               if (iss_col == CW'(NUM_COLS - 1)) begin
                  iss_col <= '0;
                  iss_row <= iss_row + 1'b1;
               end else begin
                  iss_col <= iss_col + 1'b1;
               end
            end
         end
         if (release_bank) begin
            rd_all  <= 1'b0;
            rd_bank <= ~rd_bank;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en && !wr_bank) mem0[wr_addr] <= wr_word;
      if (wr_en &&  wr_bank) mem1[wr_addr] <= wr_word;
      rd_q <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
   end

   pixel_skid_buf #(
      .DATA_WIDTH   (DATA_WIDTH),
      .NUM_CHANNELS (NUM_CHANNELS),
      .ROW_W        (RW),
      .COL_W        (CW)
   ) u_skid (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .in_valid  (pend),
      .in_data   (rd_pix),
      .in_row    (pend_row),
      .in_col    (pend_col),
      .in_first  (pend_first),
      .in_last   (pend_last),
      .out_ready (bus.i_ready),
      .out_valid (bus.o_valid),
      .out_data  (bus.o_features),
      .out_row   (bus.o_row),
      .out_col   (bus.o_col),
      .out_first (bus.o_first),
      .out_last  (bus.o_last),
      .count     (skid_cnt)
   );
endmodule

// File: tb/tb_pool_frame_buffer.sv
// Randomized bench for pool_frame_buffer against a frame-level queue model.
`timescale 1ns/1ps
module tb_pool_frame_buffer;
   import cnn_pkg::*;

   localparam int DW   = PIX_WIDTH;
   localparam int NC   = PIX_CHANNELS;
   localparam int NR   = L1_ROWS;
   localparam int NCOL = L1_COLS;
   localparam int FR   = NR * NCOL;
   localparam int PW   = DW * NC;
   localparam int RW   = $clog2(NR);
   localparam int CW   = $clog2(NCOL);

   typedef logic [PW-1:0] pvec_t;
   typedef struct { pvec_t data; int k; } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pool_frame_buffer_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .NUM_ROWS(NR), .NUM_COLS(NCOL)) bus ();

   pool_frame_buffer #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .NUM_ROWS(NR), .NUM_COLS(NCOL)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Frame-level model: frames complete in order, at most two held unreleased.
   beat_t  exp_q[$];
   pvec_t  wr_buf [FR];
   int     m_wr_idx = 0;
   bit     m_accept = 1'b0;
   int     m_out = 0;
   int     m_drops = 0;
   int     ready_mode = 1;
   bit     stalled = 1'b0;
   pvec_t  st_data;
   logic [RW+CW+2:0] st_ctl;
   logic   seen_valid;

   function automatic pvec_t out_vec();
      pvec_t v;
      for (int c = 0; c < NC; c++) v[c*DW +: DW] = bus.o_features[c];
      return v;
   endfunction

   function automatic logic [RW+CW+2:0] out_ctl();
      return {bus.o_valid, bus.o_row, bus.o_col, bus.o_first, bus.o_last};
   endfunction

   function automatic pvec_t gen_pix(input int mode, input int k);
      pvec_t v;
      for (int c = 0; c < NC; c++) begin
         case (mode)
            0:       v[c*DW +: DW] = DW'(100 * c + k);
            1:       v[c*DW +: DW] = DW'($urandom);
            default: v[c*DW +: DW] = (((c + k) % 2) == 0) ? 16'h8000 : 16'h7FFF;
         endcase
      end
      return v;
   endfunction

   task automatic step(input bit nd, input pvec_t pix, input bit arm, output bit fired);
      bit rdy, xfer, go;
      beat_t b;
      logic [RW-1:0] er;
      logic [CW-1:0] ec;
      @(negedge clk);
      seen_valid = bus.o_valid;
      if (stalled) begin
         check("hold_data", out_vec(), st_data);
         check("hold_ctl", out_ctl(), st_ctl);
      end
      rdy     = (ready_mode == 2) ? 1'($urandom_range(1, 0)) : (ready_mode == 1);
      xfer    = bus.o_valid && rdy;
      stalled = bus.o_valid && !rdy;
      if (stalled) begin
         st_data = out_vec();
         st_ctl  = out_ctl();
      end
      go = nd && (!arm || (xfer && exp_q.size() > 0 && exp_q[0].k == FR - 1));
      if (xfer) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 1, 0);
         end else begin
            b  = exp_q.pop_front();
            er = RW'(b.k / NCOL);
            ec = CW'(b.k % NCOL);
            check("beat_data", out_vec(), b.data);
            check("beat_tags", {bus.o_row, bus.o_col, bus.o_first, bus.o_last},
                  {er, ec, (b.k == 0), (b.k == FR - 1)});
            if (b.k == FR - 1) m_out--;
         end
      end
      if (go) begin
         if (m_wr_idx == 0) m_accept = (m_out < 2);
         wr_buf[m_wr_idx] = pix;
         m_wr_idx++;
         if (m_wr_idx == FR) begin
            m_wr_idx = 0;
            if (m_accept) begin
               m_out++;
               for (int k = 0; k < FR; k++) exp_q.push_back('{wr_buf[k], k});
            end else begin
               m_drops++;
            end
         end
      end
      bus.i_ready = rdy;
      bus.i_nd    = go;
      for (int c = 0; c < NC; c++) bus.i_features[c] = pix[c*DW +: DW];
      fired = go;
      @(posedge clk);
   endtask

   task automatic write_frame(input int mode, input bit gaps, input bit arm, input int n);
      bit f;
      pvec_t pix;
      for (int k = 0; k < n; k++) begin
         pix = gen_pix(mode, k);
         if (k == 0 && arm) begin
            f = 1'b0;
            for (int t = 0; t < 2000 && !f; t++) step(1'b1, pix, 1'b1, f);
            if (!f) check("arm_timeout", 0, 1);
         end else begin
            if (gaps && $urandom_range(3, 0) == 0) step(1'b0, '0, 1'b0, f);
            step(1'b1, pix, 1'b0, f);
         end
      end
   endtask

   task automatic drain();
      bit f;
      for (int t = 0; t < 3000 && exp_q.size() > 0; t++) step(1'b0, '0, 1'b0, f);
      check("drain_left", exp_q.size(), 0);
      repeat (4) step(1'b0, '0, 1'b0, f);
      check("idle_after", seen_valid, 0);
   endtask

   task automatic check_status();
      #1;
      check("overflow", bus.o_overflow, (m_drops > 0));
      check("drop_cnt", bus.o_drop_cnt, (m_drops > 255) ? 255 : m_drops);
   endtask

   task automatic check_zero();
      check("rst_valid", bus.o_valid, 0);
      check("rst_data", out_vec(), 0);
      check("rst_rowcol", {bus.o_row, bus.o_col}, 0);
      check("rst_first_last", {bus.o_first, bus.o_last}, 0);
      check("rst_overflow", bus.o_overflow, 0);
      check("rst_drop_cnt", bus.o_drop_cnt, 0);
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_wr_idx = 0;
      m_out    = 0;
      m_drops  = 0;
      stalled  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit f;
      bus.i_nd    = 1'b0;
      bus.i_ready = 1'b0;
      for (int c = 0; c < NC; c++) bus.i_features[c] = '0;
      repeat (3) @(negedge clk);
      check_zero();
      rst_n = 1'b1;

      // single frame, always ready, o_valid latency after the last strobe
      ready_mode = 1;
      write_frame(0, 1'b0, 1'b0, FR);
      step(1'b0, '0, 1'b0, f); check("lat_e0", seen_valid, 0);
      step(1'b0, '0, 1'b0, f); check("lat_e1", seen_valid, 0);
      step(1'b0, '0, 1'b0, f); check("lat_e2", seen_valid, 1);
      drain();

      // same frame, random backpressure and input gaps
      ready_mode = 2;
      write_frame(0, 1'b1, 1'b0, FR);
      drain();

      // three frames with consumer stalled: third is dropped
      ready_mode = 0;
      repeat (3) write_frame(1, 1'b0, 1'b0, FR);
      check_status();
      ready_mode = 1;
      drain();
      check_status();

      // new frame's first strobe lands on the release of the oldest frame
      ready_mode = 0;
      repeat (2) write_frame(1, 1'b0, 1'b0, FR);
      ready_mode = 1;
      write_frame(1, 1'b0, 1'b1, FR);
      check_status();
      drain();

      // extreme values, random backpressure
      ready_mode = 2;
      write_frame(2, 1'b1, 1'b0, FR);
      drain();
      check_status();

      // reset with a stored frame pending and a partial frame in progress
      ready_mode = 0;
      write_frame(1, 1'b0, 1'b0, FR);
      write_frame(1, 1'b0, 1'b0, 50);
      @(negedge clk);
      check("pre_rst_valid", bus.o_valid, 1);
      #2;
      bus.i_nd = 1'b0;
      rst_n = 1'b0;
      #1;
      check_zero();
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      ready_mode = 1;
      write_frame(0, 1'b0, 1'b0, FR);
      drain();
      check_status();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pool_frame_buffer.md
# pool_frame_buffer

Double-buffered frame store between the first max-pool stage and the second convolution stage. It captures the pooled feature stream (NUM_CHANNELS lanes in parallel, one pixel per `i_nd` strobe, raster order) into one of two banks. It then replays each completed frame in raster order over a valid/ready interface, so conv2 can run at its own pace while the next conv1/pool frame is written.

## Interface
Parameters:
- DATA_WIDTH, 16, signed feature width per channel
- NUM_CHANNELS, 6, parallel channel lanes
- NUM_ROWS, 14, pooled rows per frame
- NUM_COLS, 14, pooled columns per frame

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_features  in  DATA_WIDTH x NUM_CHANNELS (signed array)  pooled pixel, all channels
- i_nd  in  1  new-data strobe, one pixel per cycle max
- o_features  out  DATA_WIDTH x NUM_CHANNELS (signed array)  replayed pixel
- o_valid  out  1  o_features/o_row/o_col valid
- i_ready  in  1  consumer accepts this cycle
- o_row  out  clog2(NUM_ROWS)  row index of the current output pixel
- o_col  out  clog2(NUM_COLS)  column index of the current output pixel
- o_first  out  1  pixel (0,0) of a frame
- o_last  out  1  pixel (NUM_ROWS-1, NUM_COLS-1)
- o_overflow  out  1  sticky; a frame was dropped
- o_drop_cnt  out  8  dropped-frame count, saturating at 255

## Operation
- FRAME = NUM_ROWS*NUM_COLS (196).
- Storage: two banks, each FRAME words of NUM_CHANNELS*DATA_WIDTH, with synchronous read (1-cycle latency). Each bank has a `full` flag.
- Writer, state WR_ACCEPT / WR_DROP:
  - wr_bank and wr_addr (0..FRAME-1) advance only on `i_nd`.
  - The accept/drop decision is made on the strobe with wr_addr==0. If bank[wr_bank] is not full, or is being released in this same cycle, go to WR_ACCEPT. Otherwise go to WR_DROP.
  - WR_ACCEPT: write each strobe to bank[wr_bank][wr_addr]. On the strobe with wr_addr==FRAME-1, set full[wr_bank], toggle wr_bank, and wrap wr_addr to 0.
  - WR_DROP: count strobes only, with no writes. On wr_addr==FRAME-1, wrap wr_addr, set o_overflow, and increment o_drop_cnt (saturating). wr_bank is not toggled.
- Reader, state RD_IDLE / RD_STREAM:
  - RD_IDLE: go to RD_STREAM when full[rd_bank] is set.
  - RD_STREAM: issue sequential reads rd_addr 0..FRAME-1 into a 2-entry skid buffer. A read is issued only when a skid slot will be free.
  - The skid head drives the outputs. A beat transfers when o_valid && i_ready.
  - Releasing a bank: on transfer of the o_last beat, clear full[rd_bank], toggle rd_bank, and return to RD_IDLE.
- o_row/o_col are tagged to each entry at read-issue time, not recomputed at the output. o_first = (row,col)==(0,0). o_last = (row,col)==(NUM_ROWS-1, NUM_COLS-1).
- Data passes bit-exact; no arithmetic is applied to features.
- The writer and reader touch different banks by construction. The only cross-cut is the same-cycle release/accept case, which resolves to accept.

## Timing
- Reset values, all asynchronous:
  - o_valid=0, o_features=0, o_row=0, o_col=0, o_first=0, o_last=0
  - o_overflow=0, o_drop_cnt=0
  - both full flags=0, wr_bank=rd_bank=0, wr_addr=rd_addr=0
  - skid buffer empty; writer in WR_ACCEPT, reader in RD_IDLE
- Reset mid-frame discards all stored and partial data. The first `i_nd` after reset is pixel (0,0).
- Latency: if the final write strobe is sampled at edge E, full is visible after E and o_valid rises after edge E+2.
- Throughput: one beat per cycle while i_ready=1. After reads start, there are no bubbles within a frame.
- Frame-to-frame throughput: after the last beat transfers, the next frame's o_valid rises no earlier than 2 edges later.
- Output hold: o_valid and all outputs are held stable while o_valid && !i_ready. o_valid never drops without a transfer.
- An `i_nd` on every cycle is supported indefinitely, with no gaps required.

## Structure
- Shared package (cnn_pkg):
  - pixel vector typedef: logic signed [DATA_WIDTH-1:0] [NUM_CHANNELS]
  - pooled frame dimensions for layer 1, as constants
  - FRAME constant
- Sub-module `pixel_skid_buf`: 2-entry valid/ready buffer carrying pixel vector plus row, col, first and last tags.
- Bank RAMs are inferred inline, one array per bank.

## Test plan
- Single frame, ch c of pixel k = 100*c + k, i_ready=1: exactly 196 beats in raster order with matching values. o_first on beat 0 (row 0, col 0). o_last on beat 195 (row 13, col 13). o_valid first high at E+2.
- Same frame with i_ready toggled by pseudo-random pattern (≈50%): identical data sequence, and outputs stable on every stalled cycle.
- Three back-to-back frames, i_ready=0 throughout: frames 1 and 2 stored, frame 3 dropped. o_overflow=1, o_drop_cnt=1. Raising i_ready then yields frame 1 followed by frame 2, with no frame 3 data.
- Frame 3's first strobe coincides with the o_last transfer of frame 1: frame 3 is accepted, o_drop_cnt unchanged, and frame 3 is read out after frame 2.
- Extreme values -32768 and 32767 on alternating channels: passed bit-exact.
- i_rst_n pulsed low after 50 strobes of a frame: outputs zero immediately. The next 196 strobes form a clean frame read out from pixel (0,0).
